// File: rtl/exc_pkg.sv
// exc_pkg: shared types and constants for the exception sequencer
package exc_pkg;
  typedef enum logic [2:0] {IDLE, CALC, SAVE, WAIT, LOADPC, DONE} state_t;
  localparam logic [1:0] EXC_OPC = 2'b00;
  localparam logic [1:0] EXC_OVF = 2'b01;
  localparam logic [1:0] EXC_DIV0 = 2'b10;
  localparam logic [1:0] MEM_SEL_EXC = 2'b11;
  localparam logic [1:0] SRCA_PC = 2'b00;
  localparam logic [1:0] SRCA_BYTE = 2'b10;
  localparam logic [1:0] SRCB_4 = 2'b01;
  localparam logic [1:0] PC_SEL_ALU = 2'b00;
endpackage

// File: rtl/exc_prio_enc.sv
// exc_prio_enc: 3-request priority encoder, opcode > ovf > div0
//  i_req[2:0] {div0, ovf, opcode}; o_valid any request; o_cause winning cause code
module exc_prio_enc
  import exc_pkg::*;
(
  input  logic [2:0] i_req,
  output logic       o_valid,
  output logic [1:0] o_cause
);
  assign o_valid = |i_req;
  assign o_cause = i_req[0] ? EXC_OPC : i_req[1] ? EXC_OVF : i_req[2] ? EXC_DIV0 : EXC_OPC;
endmodule

// File: rtl/exception_ctrl.sv
// exception_ctrl: exception sequencer, saves PC-4 to EPC and loads PC from the vector byte
//  in : clk, reset (sync, active-high), exc_opcode/exc_ovf/exc_div0 level requests
//  out: exc_ack/exc_active/exc_done status, exc_cause, datapath mux selects, ALUOp, write strobes
//  EXC_PEND_EN: adds a pending register and the exc_pend[2:0] output
module exception_ctrl
  import exc_pkg::*;
#(
  parameter int          MEM_WAIT    = 2,
  parameter logic [3:0]  ALUOP_SUB   = 4'd2,
  parameter logic [3:0]  ALUOP_PASSA = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       exc_opcode,
  input  logic       exc_ovf,
  input  logic       exc_div0,
  output logic       exc_ack,
  output logic       exc_active,
  output logic       exc_done,
  output logic [1:0] exc_cause,
  output logic [1:0] Mux_EXC,
  output logic [1:0] Mux_MEM,
  output logic [1:0] Mux_ALUSrcA,
  output logic [1:0] Mux_ALUSrcB,
  output logic [1:0] Mux_PC,
  output logic [3:0] ALUOp,
  output logic       ALUOut_w,
  output logic       EPC_w,
`ifdef EXC_PEND_EN
  output logic [2:0] exc_pend,
`endif
  output logic       PC_w
);
  state_t     r_state;
  logic [1:0] r_cause;
  logic [2:0] r_cnt;
  logic [2:0] w_req;
  logic       w_req_v;
  logic [1:0] w_req_cause;
  logic       w_next_v;
  logic [1:0] w_next_cause;
  logic       w_vec;
  assign w_req = {exc_div0, exc_ovf, exc_opcode};
  exc_prio_enc u_req (.i_req(w_req), .o_valid(w_req_v), .o_cause(w_req_cause));
`ifdef EXC_PEND_EN
  logic [2:0] r_pend;
  logic [2:0] r_req_q;
  logic [2:0] w_pend_clr;
  exc_prio_enc u_pend (.i_req(r_pend), .o_valid(w_next_v), .o_cause(w_next_cause));
  // the bit chosen in DONE is consumed on the same edge that re-enters CALC
  assign w_pend_clr = (r_state == DONE && w_next_v) ? 3'b001 << w_next_cause : 3'b000;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend  <= 3'b000;
      r_req_q <= 3'b000;
    end else begin
      r_req_q <= w_req;
      r_pend  <= (r_pend | (w_req & ~r_req_q & {3{r_state != IDLE}})) & ~w_pend_clr;
    end
  end
  assign exc_pend = r_pend;
`else
  assign w_next_v     = 1'b0;
  assign w_next_cause = EXC_OPC;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cause <= EXC_OPC;
      r_cnt   <= 3'd0;
    end else begin
      case (r_state)
        IDLE: if (w_req_v) begin
          r_cause <= w_req_cause;
          r_state <= CALC;
        end
        CALC: r_state <= SAVE;
        SAVE: begin
          r_cnt   <= 3'(MEM_WAIT - 1);
          r_state <= WAIT;
        end
        WAIT: if (r_cnt == 3'd0) r_state <= LOADPC;
              else r_cnt <= r_cnt - 3'd1;
        LOADPC: r_state <= DONE;
        DONE: if (w_next_v) begin
          r_cause <= w_next_cause;
          r_state <= CALC;
        end else r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
  // vector address stays on the memory bus from SAVE through LOADPC
  assign w_vec       = r_state inside {SAVE, WAIT, LOADPC};
  assign exc_ack     = r_state == CALC;
  assign exc_active  = r_state != IDLE;
  assign exc_done    = r_state == DONE;
  assign exc_cause   = r_cause;
  assign Mux_EXC     = w_vec ? r_cause : 2'b00;
  assign Mux_MEM     = w_vec ? MEM_SEL_EXC : 2'b00;
  assign Mux_ALUSrcA = r_state == LOADPC ? SRCA_BYTE : SRCA_PC;
  assign Mux_ALUSrcB = r_state == CALC ? SRCB_4 : 2'b00;
  assign Mux_PC      = PC_SEL_ALU;
  assign ALUOp       = r_state == CALC ? ALUOP_SUB : r_state == LOADPC ? ALUOP_PASSA : 4'd0;
  assign ALUOut_w    = r_state == CALC;
  assign EPC_w       = r_state == SAVE;
  assign PC_w        = r_state == LOADPC;
endmodule
